// File: rtl/npu_pkg.sv
// Shared NPU definitions: unified-buffer geometry and the writeback job states.
package npu_pkg;

  localparam int unsigned ADDR_W = 4;           // buffer row address width
  localparam int unsigned DATA_W = 16;          // one buffer row
  localparam int unsigned DEPTH  = 12;          // buffer rows, wrap modulus
  localparam int unsigned CNT_W  = ADDR_W + 1;  // row count up to DEPTH

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } wb_state_e;

endpackage

// File: rtl/ub_addr_gen.sv
// Row address generator: loads a base and stride, then steps the pointer by
// stride modulo DEPTH. Shared by the write and read sequencers.
//   clk, rst_n           clock, async active-low reset
//   load                 latch base_in into the pointer and stride_in as step
//   step                 advance pointer by the latched stride (wraps at DEPTH)
//   base_in, stride_in   job base address and stride
//   ptr                  current row address
module ub_addr_gen #(
  parameter int unsigned ADDR_W = npu_pkg::ADDR_W,
  parameter int unsigned DEPTH  = npu_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [ADDR_W-1:0] stride_in,
  output logic [ADDR_W-1:0] ptr
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [ADDR_W:0]   sum;

  // Sum is one bit wider so ptr+stride never overflows before the wrap test.
  always_comb begin
    ptr_d    = ptr_q;
    stride_d = stride_q;
    sum      = {1'b0, ptr_q} + {1'b0, stride_q};
    if (load) begin
      ptr_d    = base_in;
      stride_d = stride_in;
    end else if (step) begin
      if (sum >= (ADDR_W+1)'(DEPTH)) begin
        ptr_d = ADDR_W'(sum - (ADDR_W+1)'(DEPTH));
      end else begin
        ptr_d = ADDR_W'(sum);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      stride_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      stride_q <= stride_d;
    end
  end

  // A stride of 0 or >= DEPTH would revisit or skip rows unpredictably.
  always_ff @(posedge clk) begin
    if (rst_n && load) begin
      assert (stride_in != '0 && (ADDR_W+1)'(stride_in) < (ADDR_W+1)'(DEPTH))
        else $error("ub_addr_gen: illegal stride %0d latched", stride_in);
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ub_writeback.sv
// Unified-buffer write initiator: takes a valid/ready stream of result rows and
// writes them at base + k*stride (mod DEPTH), checks in_last against the
// programmed row count and pulses done once the last write has committed.
//   clk, rst_n                 clock, async active-low reset
//   start, base_addr, stride,  job programming, sampled in IDLE only
//   num_rows
//   busy, done, err            job status (done is a one-cycle pulse, err sticky)
//   in_valid, in_ready,        upstream row stream
//   in_data, in_last
//   wr_en, wr_addr, wr_data    registered buffer write port
module ub_writeback #(
  parameter int unsigned ADDR_W = npu_pkg::ADDR_W,
  parameter int unsigned DATA_W = npu_pkg::DATA_W,
  parameter int unsigned DEPTH  = npu_pkg::DEPTH,
  parameter int unsigned CNT_W  = npu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [CNT_W-1:0]  num_rows,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  import npu_pkg::*;

  wb_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              ptr_load;
  logic              ptr_step;
  logic [ADDR_W-1:0] ptr;
  logic              hs;

  ub_addr_gen #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ptr_load),
    .step      (ptr_step),
    .base_in   (base_addr),
    .stride_in (stride),
    .ptr       (ptr)
  );

  // Ready is a pure decode of the state so upstream sees it from the clock edge.
  assign in_ready = (state_q == RUN);
  assign hs       = in_valid && in_ready;

  // Next-state, counter and write-port logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ptr_load  = 1'b0;
    ptr_step  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_load = 1'b1;
          cnt_d    = num_rows;
          err_d    = 1'b0;
          state_d  = (num_rows == '0) ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (hs) begin
          ptr_step  = 1'b1;
          cnt_d     = CNT_W'(cnt_q - CNT_W'(1));
          wr_en_d   = 1'b1;
          wr_addr_d = ptr;
          wr_data_d = in_data;
          if (cnt_q == CNT_W'(1)) begin
            state_d = FLUSH;
            if (!in_last) err_d = 1'b1;
          end else if (in_last) begin
            // Early last: keep the beat, flag it and abort the job.
            state_d = FLUSH;
            err_d   = 1'b1;
          end
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_ub_writeback.sv
// Bench for ub_writeback: job-level reference model checked every cycle, plus
// directed jobs with hand-computed addresses, data and pulse timing.
module tb_ub_writeback;

  import npu_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] stride;
  logic [CNT_W-1:0]  num_rows;
  logic              busy, done, err;
  logic              in_valid, in_ready, in_last;
  logic [DATA_W-1:0] in_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  ub_writeback dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .stride    (stride),
    .num_rows  (num_rows),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Job-level reference model: rows still owed, pointer modulo DEPTH, and a
  // two-cycle tail (flush, then done) after the job ends.
  int                m_run, m_tail, m_ptr, m_stride, m_left;
  logic              m_err;
  logic              e_wen;
  logic [ADDR_W-1:0] e_waddr;
  logic [DATA_W-1:0] e_wdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_tail = 0; m_ptr = 0; m_stride = 0; m_left = 0;
      m_err = 1'b0; e_wen = 1'b0; e_waddr = '0; e_wdata = '0;
    end else begin
      e_wen = 1'b0;
      if (m_run != 0) begin
        if (in_valid) begin
          e_wen   = 1'b1;
          e_waddr = ADDR_W'(m_ptr);
          e_wdata = in_data;
          m_ptr   = (m_ptr + m_stride) % DEPTH;
          m_left  = m_left - 1;
          if (m_left == 0 || in_last) begin
            if ((m_left == 0) != in_last) m_err = 1'b1;
            m_run  = 0;
            m_tail = 2;
          end
        end
      end else if (m_tail > 0) begin
        m_tail = m_tail - 1;
      end else if (start) begin
        m_ptr    = int'(base_addr);
        m_stride = int'(stride);
        m_left   = int'(num_rows);
        m_err    = 1'b0;
        if (num_rows == '0) m_tail = 2;
        else                m_run  = 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(m_run != 0));
    chk("wr_en",    32'(wr_en),    32'(e_wen));
    chk("wr_addr",  32'(wr_addr),  32'(e_waddr));
    chk("wr_data",  32'(wr_data),  32'(e_wdata));
    chk("busy",     32'(busy),     32'(m_run != 0 || m_tail > 0));
    chk("done",     32'(done),     32'(m_tail == 1));
    chk("err",      32'(err),      32'(m_err));
  end

  // Buffer stand-in (negedge write) and event log for the directed checks.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] log_addr [$];
  logic [DATA_W-1:0] log_data [$];
  int                log_cyc  [$];
  int                cyc = 0;
  int                done_cnt = 0;
  int                done_cyc = 0;
  int                rdy_cnt = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_en) begin
      mem[wr_addr] = wr_data;
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      log_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (in_ready) rdy_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    rdy_cnt = 0;
  endtask

  task automatic start_job(input int b, input int s, input int n);
    base_addr = ADDR_W'(b);
    stride    = ADDR_W'(s);
    num_rows  = CNT_W'(n);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Sends n beats; vpat bit i gives in_valid in step i, last_at marks in_last.
  task automatic send_rows(input int n, input int last_at, input int d0, input logic [15:0] vpat);
    int k;
    int i;
    k = 0;
    i = 0;
    while (k < n && i < 64) begin
      in_valid = (i < 16) ? vpat[i] : 1'b1;
      in_data  = DATA_W'(d0 + k);
      in_last  = (k == last_at);
      tick();
      if (in_valid) k++;
      i++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 12; i++) begin
      if (done_cnt != d0) break;
      tick();
    end
    chk(name, 32'(done_cnt != d0), 32'd1);
    tick();
  endtask

  initial begin
    int s_cyc;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; stride = '0; num_rows = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    tick();
    tick();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: contiguous job, data A,B,C at 4,5,6.
    clear_log();
    start_job(4, 1, 3);
    send_rows(3, 2, 'hA, 16'hFFFF);
    wait_done("t1_done");
    chk("t1_nwr",   32'(log_addr.size()), 32'd3);
    chk("t1_addr0", 32'(log_addr[0]), 32'd4);
    chk("t1_addr2", 32'(log_addr[2]), 32'd6);
    chk("t1_data1", 32'(log_data[1]), 32'hB);
    chk("t1_b2b",   32'(log_cyc[2] - log_cyc[0]), 32'd2);
    chk("t1_dlat",  32'(done_cyc - log_cyc[2]), 32'd1);
    chk("t1_err",   32'(err), 32'd0);
    chk("t1_rd4",   32'(mem[4]), 32'hA);
    chk("t1_rd5",   32'(mem[5]), 32'hB);
    chk("t1_rd6",   32'(mem[6]), 32'hC);

    // 2: same job with a gappy valid.
    clear_log();
    start_job(4, 1, 3);
    send_rows(3, 2, 'h20, 16'b10101);
    wait_done("t2_done");
    chk("t2_nwr",   32'(log_addr.size()), 32'd3);
    chk("t2_addr1", 32'(log_addr[1]), 32'd5);
    chk("t2_gap",   32'(log_cyc[1] - log_cyc[0]), 32'd2);
    chk("t2_dlat",  32'(done_cyc - log_cyc[2]), 32'd1);

    // 3: wrap, base DEPTH-2 stride 3 -> DEPTH-2 then 1.
    clear_log();
    start_job(DEPTH - 2, 3, 2);
    send_rows(2, 1, 'h30, 16'hFFFF);
    wait_done("t3_done");
    chk("t3_nwr",   32'(log_addr.size()), 32'd2);
    chk("t3_addr0", 32'(log_addr[0]), 32'(DEPTH - 2));
    chk("t3_addr1", 32'(log_addr[1]), 32'd1);

    // 4: empty job goes straight to flush and done.
    clear_log();
    s_cyc = cyc;
    start_job(3, 1, 0);
    wait_done("t4_done");
    chk("t4_dlat", 32'(done_cyc - s_cyc), 32'd2);
    chk("t4_nwr",  32'(log_addr.size()), 32'd0);
    chk("t4_rdy",  32'(rdy_cnt), 32'd0);
    chk("t4_err",  32'(err), 32'd0);

    // 5: early last on beat 2 of 4, then a new start clears err.
    clear_log();
    start_job(0, 2, 4);
    send_rows(2, 1, 'h50, 16'hFFFF);
    wait_done("t5_done");
    chk("t5_nwr",  32'(log_addr.size()), 32'd2);
    chk("t5_addr1", 32'(log_addr[1]), 32'd2);
    chk("t5_err",  32'(err), 32'd1);
    start_job(7, 1, 1);
    chk("t5_clr",  32'(err), 32'd0);
    send_rows(1, 0, 'h58, 16'hFFFF);
    wait_done("t5b_done");
    chk("t5b_err", 32'(err), 32'd0);

    // 6: reset mid-job, then start while busy is ignored.
    clear_log();
    start_job(2, 2, 4);
    send_rows(1, 9, 'h61, 16'hFFFF);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_wen",  32'(wr_en), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_nwr_rst", 32'(log_addr.size()), 32'd1);
    chk("t6_addr0",   32'(log_addr[0]), 32'd2);
    start_job(8, 1, 2);
    base_addr = '0; num_rows = CNT_W'(3); start = 1'b1;
    in_valid = 1'b1; in_data = DATA_W'('h71); in_last = 1'b0;
    tick();
    start = 1'b0;
    send_rows(1, 0, 'h72, 16'hFFFF);
    wait_done("t6_done");
    chk("t6_nwr",   32'(log_addr.size()), 32'd3);
    chk("t6_addr1", 32'(log_addr[1]), 32'd8);
    chk("t6_addr2", 32'(log_addr[2]), 32'd9);
    chk("t6_data2", 32'(log_data[2]), 32'h72);
    chk("t6_err",   32'(err), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
